// File: rtl/vec_ldst_unit.sv
// ---------------------------------------------------------------------------
// vec_ldst_unit
//   Strided vector load/store engine. Takes one request (base, stride, count,
//   direction) and walks `count` memory words at base, base+stride, ...
//   Loads stream the words out through a one-entry output register.
//   Stores take one word per beat from the st_* port and write it straight to
//   memory.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_*                 request port (valid/ready)
//   st_valid/st_ready/st_data    store word stream into the unit
//   ld_valid/ld_ready/ld_data/ld_last  load word stream out of the unit
//   mem_A/mem_WE/mem_WD/mem_RD   data memory (combinational read)
//   busy, done            status: not idle / one-cycle completion pulse
//   dbg_state             current FSM state, for checkers
//
// Handshake rule for every valid/ready pair: a transfer happens on the rising
// edge where both are 1. The sender keeps valid and its payload steady until
// that edge. ready may depend on state only, never on valid.
// ---------------------------------------------------------------------------
module vec_ldst_unit #(
  parameter int LANES  = 6,
  parameter int LANE_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [31:0]                    req_base,
  input  logic [31:0]                    req_stride,
  input  logic [CNT_W-1:0]               req_count,
  input  logic                           st_valid,
  output logic                           st_ready,
  input  logic [LANES-1:0][LANE_W-1:0]   st_data,
  output logic                           ld_valid,
  input  logic                           ld_ready,
  output logic [LANES-1:0][LANE_W-1:0]   ld_data,
  output logic                           ld_last,
  output logic [31:0]                    mem_A,
  output logic                           mem_WE,
  output logic [LANES-1:0][LANE_W-1:0]   mem_WD,
  input  logic [LANES-1:0][LANE_W-1:0]   mem_RD,
  output logic                           busy,
  output logic                           done,
  output logic [2:0]                     dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_LDWAIT = 3'd2,
    S_STORE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                         state_q,    state_d;
  logic [31:0]                    addr_q,     addr_d;
  logic [31:0]                    stride_q,   stride_d;
  logic [CNT_W-1:0]               beats_q,    beats_d;
  logic                           ld_valid_q, ld_valid_d;
  logic [LANES-1:0][LANE_W-1:0]   ld_data_q,  ld_data_d;
  logic                           ld_last_q,  ld_last_d;

  logic                           ld_free;
  logic                           beat_done;
  logic                           last_beat;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    stride_d   = stride_q;
    beats_d    = beats_q;
    ld_valid_d = ld_valid_q;
    ld_data_d  = ld_data_q;
    ld_last_d  = ld_last_q;
    beat_done  = 1'b0;

    // The output register can take a new word if it is empty or being drained.
    ld_free   = !ld_valid_q || ld_ready;
    last_beat = (beats_q == CNT_W'(1));

    // Drain first; a capture below in the same cycle overrides this.
    if (ld_valid_q && ld_ready) begin
      ld_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d   = req_base;
          stride_d = req_stride;
          beats_d  = req_count;
          if (req_count == '0) begin
            state_d = S_DONE;
          end else if (req_we) begin
            state_d = S_STORE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (ld_free) begin
          beat_done  = 1'b1;
          ld_data_d  = mem_RD;
          ld_valid_d = 1'b1;
          ld_last_d  = last_beat;
          if (last_beat) begin
            state_d = S_LDWAIT;
          end
        end
      end
      S_LDWAIT: begin
        // Hold off completion until the final word has been taken.
        if (ld_valid_q && ld_ready) begin
          state_d = S_DONE;
        end
      end
      S_STORE: begin
        if (st_valid) begin
          beat_done = 1'b1;
          if (last_beat) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Address wraps modulo 2^32 by plain overflow.
    if (beat_done) begin
      addr_d  = addr_q + stride_q;
      beats_d = beats_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      beats_q    <= '0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
      ld_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      beats_q    <= beats_d;
      ld_valid_q <= ld_valid_d;
      ld_data_q  <= ld_data_d;
      ld_last_q  <= ld_last_d;
    end
  end

  // Everything below decodes the state register, so reset forces these
  // outputs low (mem_WE included) without waiting for a clock edge.
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign st_ready  = (state_q == S_STORE);
  assign mem_WE    = (state_q == S_STORE) && st_valid;
  assign mem_WD    = st_data;
  assign mem_A     = ((state_q == S_LOAD) || (state_q == S_STORE)) ? addr_q : 32'h0;
  assign ld_valid  = ld_valid_q;
  assign ld_data   = ld_data_q;
  assign ld_last   = ld_last_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vec_ldst_unit.sv
// ---------------------------------------------------------------------------
// tb_vec_ldst_unit
//   Bench for vec_ldst_unit. A 4096-word memory answers mem_A[13:2]. A
//   reference model tracks the expected memory image, the address walk and
//   the load output register. It works from request-level rules: the k-th
//   beat uses base + k*stride, a load word can enter an empty or draining
//   output register, and completion follows the last write or the last
//   consumed load word.
// ---------------------------------------------------------------------------
module tb_vec_ldst_unit;

  localparam int LANES  = 6;
  localparam int LANE_W = 8;
  localparam int CNT_W  = 4;
  localparam int W      = LANES * LANE_W;

  typedef logic [W-1:0] word_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic                          req_valid  = 1'b0;
  logic                          req_ready;
  logic                          req_we     = 1'b0;
  logic [31:0]                   req_base   = '0;
  logic [31:0]                   req_stride = '0;
  logic [CNT_W-1:0]              req_count  = '0;
  logic                          st_valid   = 1'b0;
  logic                          st_ready;
  logic [LANES-1:0][LANE_W-1:0]  st_data    = '0;
  logic                          ld_valid;
  logic                          ld_ready   = 1'b0;
  logic [LANES-1:0][LANE_W-1:0]  ld_data;
  logic                          ld_last;
  logic [31:0]                   mem_A;
  logic                          mem_WE;
  logic [LANES-1:0][LANE_W-1:0]  mem_WD;
  logic [LANES-1:0][LANE_W-1:0]  mem_RD;
  logic                          busy;
  logic                          done;
  logic [2:0]                    dbg_state;

  vec_ldst_unit #(.LANES(LANES), .LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_base   (req_base),
    .req_stride (req_stride),
    .req_count  (req_count),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_data    (st_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .mem_A      (mem_A),
    .mem_WE     (mem_WE),
    .mem_WD     (mem_WD),
    .mem_RD     (mem_RD),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- memory attached to the DUT ----------------
  word_t ram [0:4095];
  logic  ram_init = 1'b1;

  assign mem_RD = ram[mem_A[13:2]];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 4096; i++) ram[i] <= word_t'(i);
    end else if (mem_WE) begin
      ram[mem_A[13:2]] <= mem_WD;
    end
  end

  // ---------------- scoreboard state ----------------
  word_t      ref_ram [0:4095];
  logic [W-1:0] exp_q[$];      // issued load words not yet consumed
  logic       last_q[$];       // matching ld_last expectations
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver + per-cycle model ----------------
  // abort_at >= 0: pull rst_n low once that many beats have completed.
  task automatic run_req(input logic we, input logic [31:0] base,
                         input logic [31:0] stride, input logic [CNT_W-1:0] cnt,
                         input int st_prob, input int ld_prob,
                         input logic [31:0] ld_pat, input bit use_pat,
                         input int abort_at, output int done_at);
    word_t       st_words [16];
    int          c;
    int          beats;
    logic [31:0] m_addr;
    logic        issuing, ld_beat, st_beat;

    for (int k = 0; k < 16; k++) st_words[k] = word_t'({$urandom(), $urandom()});
    done_at = (cnt == 0) ? 1 : -1;
    beats   = 0;
    m_addr  = base;
    exp_q.delete();
    last_q.delete();

    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_we     = we;
    req_base   = base;
    req_stride = stride;
    req_count  = cnt;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom_range(1));
    req_base   = $urandom();
    req_stride = $urandom();
    req_count  = CNT_W'($urandom_range(15));
    c = 1;

    forever begin
      st_valid = we && ($urandom_range(99) < st_prob);
      st_data  = (beats < int'(cnt)) ? st_words[beats] : word_t'({$urandom(), $urandom()});
      ld_ready = use_pat ? ld_pat[c % 32] : ($urandom_range(99) < ld_prob);

      if (abort_at >= 0 && beats == abort_at) begin
        st_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("abort_mem_WE", mem_WE, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_st_ready", st_ready, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_ld_valid", ld_valid, 1'b0);
        chk("abort_mem_A", mem_A, 32'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        done_at = -2;
        return;
      end

      @(negedge clk);
      issuing = (cnt != 0) && (beats < int'(cnt));
      ld_beat = issuing && !we && (exp_q.size() == 0 || ld_ready);
      st_beat = issuing && we && st_valid;

      chk("mem_A", mem_A, issuing ? m_addr : 32'h0);
      chk("mem_WE", mem_WE, st_beat);
      if (st_beat) chk("mem_WD", mem_WD, st_words[beats]);
      chk("st_ready", st_ready, issuing && we);
      chk("ld_valid", ld_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("ld_data", ld_data, exp_q[0]);
        chk("ld_last", ld_last, last_q[0]);
      end
      chk("done", done, c == done_at);
      chk("busy", busy, 1'b1);
      chk("req_ready_busy", req_ready, 1'b0);

      if (c == done_at) break;

      // Model the upcoming rising edge: drain, then capture, then advance.
      if (exp_q.size() != 0 && ld_ready) begin
        if (last_q[0]) done_at = c + 1;
        void'(exp_q.pop_front());
        void'(last_q.pop_front());
      end
      if (ld_beat) begin
        exp_q.push_back(ref_ram[m_addr[13:2]]);
        last_q.push_back(beats == int'(cnt) - 1);
      end
      if (st_beat) begin
        ref_ram[m_addr[13:2]] = st_words[beats];
        if (beats == int'(cnt) - 1) done_at = c + 1;
      end
      if (ld_beat || st_beat) begin
        m_addr = m_addr + stride;
        beats++;
      end

      if (c >= 100) begin
        checks++;
        errors++;
        $display("FAIL timeout actual=no_done expected=done_within_100 t=%0t", $time);
        break;
      end
      @(posedge clk); #1;
      c++;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic              we;
    logic [31:0]       base;
    logic [31:0]       stride;
    logic [CNT_W-1:0]  cnt;
    int                st_prob;
    int                ld_prob;
    logic [31:0]       ld_pat;
    bit                use_pat;
    int                exp_done;   // cycle after accept carrying done, -1 = unchecked
  } vec_t;

  vec_t vecs [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d;
    logic        r_we;
    logic [31:0] r_base, r_stride;

    for (int i = 0; i < 4096; i++) ref_ram[i] = word_t'(i);

    //           we    base          stride  cnt  stp  ldp  pattern       pat   done
    vecs[0] = '{1'b0, 32'h10,       32'd4,  4'd3, 100, 100, 32'h0,       1'b0, 5};
    vecs[1] = '{1'b1, 32'h40,       32'd8,  4'd2, 100, 100, 32'h0,       1'b0, 3};
    vecs[2] = '{1'b0, 32'h80,       32'd4,  4'd0, 100, 100, 32'h0,       1'b0, 1};
    vecs[3] = '{1'b1, 32'h80,       32'd4,  4'd0, 100, 100, 32'h0,       1'b0, 1};
    vecs[4] = '{1'b0, 32'hFFFFFFFC, 32'd4,  4'd2, 100, 100, 32'h0,       1'b0, 4};
    vecs[5] = '{1'b0, 32'h10,       32'd4,  4'd3, 100, 100, 32'hFFFFFFC7, 1'b1, 8};
    vecs[6] = '{1'b1, 32'h100,      32'd12, 4'd15, 100, 100, 32'h0,      1'b0, 16};
    vecs[7] = '{1'b0, 32'h100,      32'd12, 4'd15, 100, 100, 32'h0,      1'b0, 17};
    vecs[8] = '{1'b1, 32'hFFFFFFF8, 32'd4,  4'd3, 100, 100, 32'h0,       1'b0, 4};

    // reset values, with a store word offered to prove mem_WE stays low
    st_valid = 1'b1;
    #2;
    chk("rst_ld_valid", ld_valid, 1'b0);
    chk("rst_ld_last", ld_last, 1'b0);
    chk("rst_ld_data", ld_data, '0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_WE", mem_WE, 1'b0);
    chk("rst_st_ready", st_ready, 1'b0);
    chk("rst_mem_A", mem_A, 32'h0);
    chk("rst_dbg_state", dbg_state, 3'd0);
    st_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ram_init = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 1'b1);

    for (int i = 0; i < 9; i++) begin
      run_req(vecs[i].we, vecs[i].base, vecs[i].stride, vecs[i].cnt,
              vecs[i].st_prob, vecs[i].ld_prob, vecs[i].ld_pat, vecs[i].use_pat, -1, d);
      if (vecs[i].exp_done >= 0) chk($sformatf("done_lat_%0d", i), d, vecs[i].exp_done);
    end

    // randomized requests with random handshakes
    for (int i = 0; i < 40; i++) begin
      r_we     = 1'($urandom_range(1));
      r_base   = ($urandom_range(1) == 1) ? $urandom() : 32'($urandom_range(255)) << 2;
      case ($urandom_range(3))
        0:       r_stride = 32'd4;
        1:       r_stride = 32'($urandom_range(15)) << 2;
        2:       r_stride = $urandom();
        default: r_stride = 32'd0;
      endcase
      run_req(r_we, r_base, r_stride, CNT_W'($urandom_range(15)),
              $urandom_range(100, 30), $urandom_range(100, 30), 32'h0, 1'b0, -1, d);
    end

    // reset after the first of four store beats, then read the region back
    run_req(1'b1, 32'h200, 32'd4, 4'd4, 100, 100, 32'h0, 1'b0, 1, d);
    run_req(1'b0, 32'h200, 32'd4, 4'd4, 100, 100, 32'h0, 1'b0, -1, d);
    chk("after_abort_done_lat", d, 6);
    chk("abort_untouched_word", ram[32'h204 >> 2], ref_ram[32'h204 >> 2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_ldst_unit.md
VEC_LDST_UNIT -- requirements
Module: vec_ldst_unit

Interface
REQ-001 SHALL have parameter LANES, default 6: number of byte lanes per memory word.
REQ-002 SHALL have parameter LANE_W, default 8: bits per lane.
REQ-003 SHALL have parameter CNT_W, default 4: width of the beat count (max 15 words per request).
REQ-004 SHALL use one clock, clk, with asynchronous active-low reset rst_n.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- rst_n  in  1  async active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_base  in  32  byte address of first word
- req_stride  in  32  byte increment between words
- req_count  in  CNT_W  number of words
- st_valid  in  1  store word offered
- st_ready  out  1  store word accepted this cycle
- st_data  in  [LANES-1:0][LANE_W-1:0]  store word
- ld_valid  out  1  load word held in output register
- ld_ready  in  1  consumer takes ld_data
- ld_data  out  [LANES-1:0][LANE_W-1:0]  load word
- ld_last  out  1  ld_data is the final word of the request
- mem_A  out  32  data memory byte address
- mem_WE  out  1  data memory write enable
- mem_WD  out  [LANES-1:0][LANE_W-1:0]  data memory write data
- mem_RD  in  [LANES-1:0][LANE_W-1:0]  data memory read data, combinational from mem_A
- busy  out  1  state != IDLE
- done  out  1  one-cycle request-complete pulse

Function
REQ-006 SHALL implement the states IDLE, LOAD, LDWAIT, STORE, and DONE.
REQ-007 IDLE: req_ready=1; on req_valid, latch base/stride/count/we into internal registers and set addr=base and beats=count; if count==0, go to DONE, else if we, go to STORE, else go to LOAD.
REQ-008 SHALL hold req_ready=0 in every state other than IDLE; req_valid SHALL be ignored there.
REQ-009 mem_A SHALL equal addr in LOAD and STORE, else 0; the unit SHALL pass all 32 bits unmodified, and the memory SHALL use bits [13:2].
REQ-010 After each completed beat: addr += stride, modulo 2^32 (wrap, no error); beats -= 1.
REQ-011 LOAD: a beat completes when the output register is free (ld_valid==0 or ld_ready==1).
- On completion, ld_data<=mem_RD, ld_valid<=1, ld_last<=(beats==1).
- If the beat is not completed, addr SHALL hold.
REQ-012 LOAD: after the last beat completes, go to LDWAIT; LDWAIT SHALL go to DONE on the cycle when ld_valid && ld_ready.
REQ-013 ld_valid SHALL clear on ld_ready when no new beat is captured in the same cycle; ld_data and ld_last SHALL be stable while ld_valid && !ld_ready.
REQ-014 STORE: st_ready=1; mem_WE=st_valid (combinational); mem_WD=st_data.
- A beat completes on st_valid; the memory writes on that rising edge.
- After the last beat, go to DONE.
REQ-015 mem_WE SHALL be 0 in every state except STORE; st_ready SHALL be 0 outside STORE; ld_valid SHALL never be newly set outside LOAD.
REQ-016 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-017 Throughput: one word per cycle with ld_ready/st_valid held high. The first load word SHALL appear with ld_valid at T+2, where T is the accept cycle; store st_ready SHALL rise at T+1.

Reset
REQ-018 When rst_n is low, the following SHALL hold immediately (asynchronously): state=IDLE, ld_valid=0, ld_last=0, ld_data=0, addr=0, beats=0, done=0, busy=0; mem_WE=0; st_ready=0; req_ready=1 once rst_n goes high.
REQ-019 Reset mid-request SHALL abandon the remaining beats; no memory write SHALL occur on or after the reset assertion.

Verification
REQ-020 Load: base=0x10, stride=4, count=3, ld_ready=1 -> mem_A=0x10,0x14,0x18 on T+1..T+3; ld_valid on T+2..T+4 with RAM words 4,5,6; ld_last only on the third word; done at T+5.
REQ-021 Store: base=0x40, stride=8, count=2, st_valid held with data D0, D1 -> mem_WE=1 on T+1 and T+2 with mem_A=0x40/0x48 and mem_WD=D0/D1; done at T+3; no third write.
REQ-022 Backpressure: load count=3 with ld_ready=0 for 3 cycles while holding word 2 -> ld_data stable; mem_A holds 0x18; consumer sees exactly words 4, 5, 6 in order.
REQ-023 Zero count: count=0 (load or store) -> no mem_WE, no ld_valid; done at T+1; req_ready=1 at T+2.
REQ-024 Wrap: base=0xFFFFFFFC, stride=4, count=2 -> mem_A=0xFFFFFFFC then 0x00000000.
REQ-025 Reset mid-store: rst_n low after the first of 4 beats -> mem_WE=0 in the same cycle; busy=0; only one word is written to memory; after release, req_ready=1 and a new request completes normally.
